// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder slice.
// Optional address checking in the top is enabled by defining MEM_RESP_ALIGN_CHK_EN.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam int   LANE_W    = 2;
  localparam int   CNT_W     = 4;

  function automatic logic [3:0] lane_be(input logic [LANE_W-1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = 4'b0001;
      2'd1:    be = 4'b0010;
      2'd2:    be = 4'b0100;
      2'd3:    be = 4'b1000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [LANE_W-1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word-organised storage with per-byte write enables and combinational read.
// Contents start at zero and are never touched by reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] r_mem [DEPTH] = '{default: 32'h0000_0000};

  // byte-lane write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE -> BUSY -> DONE handshake over mem_resp_array.
// Define MEM_RESP_ALIGN_CHK_EN to reject misaligned word accesses and out-of-range addresses.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_or_word,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        addr_error
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_idx;
  logic [LANE_W-1:0]  r_lane;
  logic [31:0]        r_wdata;
  logic               r_size;
  logic               r_write;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic               r_mem_ready;

  logic               w_req;
  logic               w_in_idle;
  logic               w_accept;
  logic               w_enter_done;
  logic               w_align_err;
  logic               w_acc_err;
  logic [ADDR_W-1:0]  w_cur_idx;
  logic [LANE_W-1:0]  w_cur_lane;
  logic [31:0]        w_cur_wdata;
  logic               w_cur_size;
  logic               w_cur_write;
  logic               w_cur_err;
  logic               w_we;
  logic [3:0]         w_be;
  logic [31:0]        w_arr_wdata;
  logic [31:0]        w_arr_rdata;
  logic [31:0]        w_rd_data;

  assign w_req     = mem_read | mem_write;
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle & w_req;

`ifdef MEM_RESP_ALIGN_CHK_EN
  assign w_align_err = ((byte_or_word == SIZE_WORD) && (address[1:0] != 2'b00)) ||
                       ((address >> (ADDR_W + 2)) != 32'h0000_0000);
`else
  logic w_unused_addr;
  assign w_align_err   = 1'b0;
  assign w_unused_addr = |(address >> (ADDR_W + 2));
`endif

  assign w_acc_err = (mem_read & mem_write) | w_align_err;

  // With LATENCY=1 the accept edge is also the DONE-entry edge, so use live inputs in IDLE.
  assign w_cur_idx   = w_in_idle ? address[ADDR_W+1:2] : r_idx;
  assign w_cur_lane  = w_in_idle ? address[LANE_W-1:0] : r_lane;
  assign w_cur_wdata = w_in_idle ? wdata               : r_wdata;
  assign w_cur_size  = w_in_idle ? byte_or_word        : r_size;
  assign w_cur_write = w_in_idle ? mem_write           : r_write;
  assign w_cur_err   = w_in_idle ? w_acc_err           : r_err;

  assign w_we        = w_enter_done & w_cur_write & ~w_cur_err;
  assign w_be        = (w_cur_size == SIZE_WORD) ? 4'b1111 : lane_be(w_cur_lane);
  assign w_arr_wdata = (w_cur_size == SIZE_WORD) ? w_cur_wdata : {4{w_cur_wdata[7:0]}};
  assign w_rd_data   = (w_cur_size == SIZE_WORD) ? w_arr_rdata
                                                 : {24'h00_0000, lane_byte(w_arr_rdata, w_cur_lane)};

  mem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_be),
    .i_idx   (w_cur_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    w_enter_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_next_state = ST_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_next_state = ST_BUSY;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_next_state = ST_DONE;
          w_enter_done = 1'b1;
        end else begin
          w_next_state = ST_BUSY;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // state, latched request and latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {ADDR_W{1'b0}};
      r_lane  <= {LANE_W{1'b0}};
      r_wdata <= 32'h0000_0000;
      r_size  <= SIZE_WORD;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_idx   <= address[ADDR_W+1:2];
        r_lane  <= address[LANE_W-1:0];
        r_wdata <= wdata;
        r_size  <= byte_or_word;
        r_write <= mem_write;
        r_err   <= w_acc_err;
      end else if ((r_state == ST_BUSY) && (r_cnt != {CNT_W{1'b0}})) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // completion outputs, updated only on DONE entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata     <= 32'h0000_0000;
      r_mem_ready <= 1'b0;
    end else begin
      r_mem_ready <= w_enter_done;
      if (w_enter_done) begin
        if (w_cur_err) begin
          r_rdata <= 32'h0000_0000;
        end else if (!w_cur_write) begin
          r_rdata <= w_rd_data;
        end
      end
    end
  end

  assign rdata     = r_rdata;
  assign mem_ready = r_mem_ready;

`ifdef MEM_RESP_ALIGN_CHK_EN
  logic r_addr_error;

  // error flag pulses alongside mem_ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_error <= 1'b0;
    end else begin
      r_addr_error <= w_enter_done & w_cur_err;
    end
  end

  assign addr_error = r_addr_error;
`else
  assign addr_error = 1'b0;
`endif

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of array depth in 32-bit words (256 words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request acceptance to mem_ready; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 mem_read  in  1  read request strobe from the control unit.
REQ-006 mem_write  in  1  write request strobe from the control unit.
REQ-007 byte_or_word  in  1  access size: 0 = 32-bit word, 1 = byte.
REQ-008 address  in  32  byte address.
REQ-009 wdata  in  32  write data; for byte writes, bits [7:0] are used.
REQ-010 rdata  out  32  read data; byte reads are zero-extended.
REQ-011 mem_ready  out  1  one-cycle pulse: access complete, rdata valid.
REQ-012 addr_error  out  1  one-cycle pulse, coincident with mem_ready: access rejected.

Function
REQ-013 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 In IDLE, a request (mem_read or mem_write high) SHALL be accepted on the rising edge and SHALL latch address, wdata, byte_or_word and direction.
REQ-015 After acceptance, the FSM SHALL stay in BUSY for LATENCY-1 cycles; for LATENCY=1, it SHALL go directly to DONE.
REQ-016 mem_ready SHALL be high exactly during the DONE cycle, LATENCY edges after the accept edge.
REQ-017 Strobes in BUSY or DONE SHALL be ignored; a strobe still high in IDLE after DONE is a new request, so the initiator SHALL drop strobes in the mem_ready cycle.
REQ-018 Word read: rdata = array[address[ADDR_W+1:2]].
REQ-019 Byte read: rdata = {24'b0, lane address[1:0]}, little-endian (lane 0 = bits [7:0]).
REQ-020 Word write SHALL update the array on the edge entering DONE.
REQ-021 Byte write SHALL modify only lane address[1:0] and leave the other three bytes unchanged.
REQ-022 rdata SHALL hold its last value outside DONE; after a write, rdata SHALL be unchanged.
REQ-023 mem_read and mem_write high together SHALL be an error: no array update, addr_error pulsed with mem_ready.
REQ-024 An erroneous access SHALL NOT modify the array; rdata SHALL be 32'h0 in the error DONE cycle.

Reset
REQ-025 On reset low, asynchronously: state = IDLE; rdata = 0; mem_ready = 0; addr_error = 0; latched request cleared.
REQ-026 Reset during BUSY SHALL abandon the access; a pending write SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be affected by reset.

Configuration
REQ-028 Macro MEM_RESP_ALIGN_CHK_EN defined: a word access with address[1:0] != 0, or any access with address[31:ADDR_W+2] != 0, SHALL be rejected per REQ-024 and SHALL pulse addr_error.
REQ-029 Macro MEM_RESP_ALIGN_CHK_EN undefined: addr_error SHALL be constant 0; word accesses SHALL ignore address[1:0]; upper address bits SHALL be ignored (wrap); REQ-023 still applies, with addr_error held 0.

Structure
REQ-030 Package mem_resp_pkg SHALL hold the FSM state encoding, the SIZE_WORD/SIZE_BYTE constants and the lane-select width.
REQ-031 Storage SHALL be in one sub-module, mem_resp_array: synchronous write, 4-lane byte-enable, combinational word read.
REQ-032 The array SHALL initialise to all zeros at time 0 for simulation.

Verification
REQ-033 Word write 32'hDEADBEEF at 0x10, then word read 0x10 -> mem_ready 2 cycles after each accept; rdata = 32'hDEADBEEF.
REQ-034 Byte write 8'h5A at 0x13 over 32'h11223344 at 0x10, then word read 0x10 -> 32'h5A223344; byte read 0x12 -> 32'h00000022.
REQ-035 mem_read and mem_write high together at 0x20 -> addr_error and mem_ready pulse together; array word at 0x20 unchanged.
REQ-036 With MEM_RESP_ALIGN_CHK_EN: word read at 0x02 -> addr_error=1, rdata=0. Without the macro: the same read returns word 0x00 and addr_error=0.
REQ-037 Word write accepted, then reset low in BUSY -> outputs 0 at once, state IDLE; a later read of that address returns the old value.
REQ-038 LATENCY=1: back-to-back reads with the strobe dropped during mem_ready -> one mem_ready per request, each 1 edge after accept.
